tape_pulse_generator: RTL and testbench

Tape playback source for the emulated cassette port. Takes block bytes over a valid/ready stream and produces the square-wave level the tape interface samples as its tape input: pilot tone, two sync half-pulses, then each data bit as two equal half-pulses, then a trailing pause. Sits directly upstream of the tape interface's tape-input pin. All lengths are counted in CLK cycles.

---
 rtl/tape_pkg.sv | 32 +++
 rtl/tape_half_timer.sv | 42 ++++
 rtl/tape_pulse_generator.sv | 266 ++++++++++++++++++++++++++
 tb/tb_tape_pulse_generator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tape_pkg
//  Description : Shared types and default timing for the tape pulse generator.
//                Holds the FSM state enum, the default half-pulse / pause
//                lengths (in CLK cycles) and the counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package tape_pkg;

    // Counter width; must hold every timing length below.
    localparam int CNT_W = 22;

    localparam int c_pilot_half   = 2168;
    localparam int c_pilot_count  = 8063;
    localparam int c_sync1_half   = 667;
    localparam int c_sync2_half   = 735;
    localparam int c_zero_half    = 855;
    localparam int c_one_half     = 1710;
    localparam int c_pause_cycles = 3500000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PILOT = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SYNC2 = 3'd3,
        ST_DATA  = 3'd4,
        ST_PAUSE = 3'd5
    } tape_state_t;

endpackage
`default_nettype wire

// File: rtl/tape_half_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tape_half_timer
//  Description : Loadable down-counter used for both half-pulse and pause
//                timing. A load of N-1 followed by N-1 enabled decrements
//                reaches zero; o_done is high while the count is zero.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_en           - count enable (motor on)
//                i_load         - load i_load_val (wins over counting)
//                i_load_val     - value to load
//                o_done         - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module tape_half_timer
    import tape_pkg::*;
#(
    parameter int CNT_W = tape_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tape_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tape_pulse_generator
//  Description : Tape playback source. Accepts block bytes on a valid/ready
//                stream and produces the tape square wave: pilot tone, two
//                sync half-pulses, data bits (MSB first, two equal halves per
//                bit) and a trailing pause forced low.
//  Ports       : CLK, RESET          - clock, synchronous active-high reset
//                ENABLE              - motor on; low freezes all timing
//                S_VALID/S_READY     - byte handshake
//                S_DATA, S_LAST      - byte and end-of-block flag
//                TAPE_LEVEL          - generated tape signal
//                BUSY                - not idle
//                UNDERRUN            - sticky: byte missing at a boundary
//  Revision    : 1.0  initial release
// ============================================================================
module tape_pulse_generator
    import tape_pkg::*;
#(
    parameter int PILOT_HALF   = c_pilot_half,
    parameter int PILOT_COUNT  = c_pilot_count,
    parameter int SYNC1_HALF   = c_sync1_half,
    parameter int SYNC2_HALF   = c_sync2_half,
    parameter int ZERO_HALF    = c_zero_half,
    parameter int ONE_HALF     = c_one_half,
    parameter int PAUSE_CYCLES = c_pause_cycles,
    parameter int CNT_W        = tape_pkg::CNT_W
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       S_VALID,
    output logic       S_READY,
    input  logic [7:0] S_DATA,
    input  logic       S_LAST,
    output logic       TAPE_LEVEL,
    output logic       BUSY,
    output logic       UNDERRUN
);

    // Counters load N-1 so that the level holds for exactly N cycles.
    localparam logic [CNT_W-1:0] c_pilot_ld = CNT_W'(PILOT_HALF - 1);
    localparam logic [CNT_W-1:0] c_pcnt_ld  = CNT_W'(PILOT_COUNT - 1);
    localparam logic [CNT_W-1:0] c_sync1_ld = CNT_W'(SYNC1_HALF - 1);
    localparam logic [CNT_W-1:0] c_sync2_ld = CNT_W'(SYNC2_HALF - 1);
    localparam logic [CNT_W-1:0] c_zero_ld  = CNT_W'(ZERO_HALF - 1);
    localparam logic [CNT_W-1:0] c_one_ld   = CNT_W'(ONE_HALF - 1);
    localparam logic [CNT_W-1:0] c_pause_ld = CNT_W'(PAUSE_CYCLES - 1);

    tape_state_t      r_state, w_next_state;
    logic             r_level;
    logic             r_underrun;
    logic [7:0]       r_hold_byte;
    logic             r_hold_last;
    logic             r_hold_full;
    logic             r_last_seen;
    logic [7:0]       r_shift;       // bit in flight is r_shift[7]
    logic             r_cur_last;
    logic [2:0]       r_bits_left;   // bits still to send after the current one
    logic             r_second_half;
    logic [CNT_W-1:0] r_pilot_cnt;

    logic             w_accept;
    logic             w_timer_done;
    logic             w_toggle;
    logic             w_force_low;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_pilot_load;
    logic             w_pilot_dec;
    logic             w_boundary;
    logic             w_consume;
    logic             w_bit_next;
    logic             w_half2;
    logic             w_set_ur;
    logic             w_clr_ur;

    assign S_READY    = !r_hold_full && !r_last_seen;
    assign w_accept   = S_VALID && S_READY;
    assign TAPE_LEVEL = r_level;
    assign BUSY       = (r_state != ST_IDLE);
    assign UNDERRUN   = r_underrun;

    tape_half_timer #(
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RESET),
        .i_en       (ENABLE),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_toggle     = 1'b0;
        w_force_low  = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_pilot_load = 1'b0;
        w_pilot_dec  = 1'b0;
        w_boundary   = 1'b0;
        w_consume    = 1'b0;
        w_bit_next   = 1'b0;
        w_half2      = 1'b0;
        w_set_ur     = 1'b0;
        w_clr_ur     = 1'b0;
        if (ENABLE) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        w_next_state = ST_PILOT;
                        w_toggle     = 1'b1;
                        w_load       = 1'b1;
                        w_load_val   = c_pilot_ld;
                        w_pilot_load = 1'b1;
                        w_clr_ur     = 1'b1;
                    end
                end
                ST_PILOT: begin
                    if (w_timer_done) begin
                        w_toggle = 1'b1;
                        w_load   = 1'b1;
                        if (r_pilot_cnt == '0) begin
                            w_next_state = ST_SYNC1;
                            w_load_val   = c_sync1_ld;
                        end else begin
                            w_pilot_dec = 1'b1;
                            w_load_val  = c_pilot_ld;
                        end
                    end
                end
                ST_SYNC1: begin
                    if (w_timer_done) begin
                        w_next_state = ST_SYNC2;
                        w_toggle     = 1'b1;
                        w_load       = 1'b1;
                        w_load_val   = c_sync2_ld;
                    end
                end
                ST_SYNC2: begin
                    w_boundary = w_timer_done;
                end
                ST_DATA: begin
                    if (w_timer_done) begin
                        if (!r_second_half) begin
                            w_half2    = 1'b1;
                            w_toggle   = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = r_shift[7] ? c_one_ld : c_zero_ld;
                        end else if (r_bits_left != 3'd0) begin
                            w_bit_next = 1'b1;
                            w_toggle   = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = r_shift[6] ? c_one_ld : c_zero_ld;
                        end else if (r_cur_last) begin
                            w_next_state = ST_PAUSE;
                            w_force_low  = 1'b1;
                            w_load       = 1'b1;
                            w_load_val   = c_pause_ld;
                        end else begin
                            w_boundary = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_timer_done) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
            // A boundary with an empty hold register stalls in place: the
            // state and the expired timer are kept, so it is retried each
            // cycle and resumes the cycle after the hold register fills.
            if (w_boundary) begin
                if (r_hold_full) begin
                    w_consume    = 1'b1;
                    w_next_state = ST_DATA;
                    w_toggle     = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = r_hold_byte[7] ? c_one_ld : c_zero_ld;
                end else begin
                    w_set_ur = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_level       <= 1'b0;
            r_underrun    <= 1'b0;
            r_hold_byte   <= 8'd0;
            r_hold_last   <= 1'b0;
            r_hold_full   <= 1'b0;
            r_last_seen   <= 1'b0;
            r_shift       <= 8'd0;
            r_cur_last    <= 1'b0;
            r_bits_left   <= 3'd0;
            r_second_half <= 1'b0;
            r_pilot_cnt   <= '0;
        end else begin
            if (w_force_low) begin
                r_level <= 1'b0;
            end else if (w_toggle) begin
                r_level <= ~r_level;
            end

            if (w_clr_ur) begin
                r_underrun <= 1'b0;
            end else if (w_set_ur) begin
                r_underrun <= 1'b1;
            end

            // Consume and accept are exclusive: accept needs an empty hold.
            if (w_consume) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_byte <= S_DATA;
                r_hold_last <= S_LAST;
                r_hold_full <= 1'b1;
            end

            // Cleared only once idle with nothing pending, so the byte that
            // starts a block never re-opens the stream behind itself.
            if (w_accept && S_LAST) begin
                r_last_seen <= 1'b1;
            end else if ((r_state == ST_IDLE) && !r_hold_full) begin
                r_last_seen <= 1'b0;
            end

            if (w_consume) begin
                r_shift       <= r_hold_byte;
                r_cur_last    <= r_hold_last;
                r_bits_left   <= 3'd7;
                r_second_half <= 1'b0;
            end else if (w_bit_next) begin
                r_shift       <= {r_shift[6:0], 1'b0};
                r_bits_left   <= r_bits_left - 3'd1;
                r_second_half <= 1'b0;
            end else if (w_half2) begin
                r_second_half <= 1'b1;
            end

            if (w_pilot_load) begin
                r_pilot_cnt <= c_pcnt_ld;
            end else if (w_pilot_dec) begin
                r_pilot_cnt <= r_pilot_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tape_pulse_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tape_pulse_generator
//  Description : Self-checking bench for tape_pulse_generator with short
//                timing parameters. A reference model expands each block into
//                a queue of half-pulse lengths and plays it cycle by cycle;
//                DUT outputs are compared against it on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tape_pulse_generator;

    localparam int PH = 4;
    localparam int PC = 3;
    localparam int S1 = 2;
    localparam int S2 = 3;
    localparam int ZH = 2;
    localparam int OH = 4;
    localparam int PS = 10;

    logic       CLK;
    logic       RESET;
    logic       ENABLE;
    logic       S_VALID;
    logic       S_READY;
    logic [7:0] S_DATA;
    logic       S_LAST;
    logic       TAPE_LEVEL;
    logic       BUSY;
    logic       UNDERRUN;

    tape_pulse_generator #(
        .PILOT_HALF   (PH),
        .PILOT_COUNT  (PC),
        .SYNC1_HALF   (S1),
        .SYNC2_HALF   (S2),
        .ZERO_HALF    (ZH),
        .ONE_HALF     (OH),
        .PAUSE_CYCLES (PS),
        .CNT_W        (22)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_DATA     (S_DATA),
        .S_LAST     (S_LAST),
        .TAPE_LEVEL (TAPE_LEVEL),
        .BUSY       (BUSY),
        .UNDERRUN   (UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    bit chk_on  = 1'b0;
    bit rand_en = 1'b0;
    bit en_dir  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode = 0;     // 0 idle, 1 pulses, 2 pause
    int         m_rem  = 0;     // cycles the present level still holds
    int         q_len[$];       // pending half-pulse lengths
    bit         m_lvl = 0, m_ur = 0, m_hold_full = 0, m_hold_last = 0;
    bit         m_last_seen = 0, m_cur_last = 0, m_in_data = 0;
    logic [7:0] m_hold_byte = 8'd0;

    task automatic next_segment();
        int len;
        if (q_len.size() > 0) begin
            m_lvl = ~m_lvl;
            m_rem = q_len.pop_front();
        end else if (m_cur_last) begin
            m_mode    = 2;
            m_lvl     = 1'b0;
            m_rem     = PS;
            m_in_data = 1'b0;
        end else if (m_hold_full) begin
            for (int i = 7; i >= 0; i--) begin
                len = m_hold_byte[i] ? OH : ZH;
                q_len.push_back(len);
                q_len.push_back(len);
            end
            m_cur_last  = m_hold_last;
            m_hold_full = 1'b0;
            m_in_data   = 1'b1;
            m_lvl       = ~m_lvl;
            m_rem       = q_len.pop_front();
        end else begin
            m_ur = 1'b1;   // stall: m_rem stays 1, retried next edge
        end
    endtask

    task automatic model_step();
        bit acc;
        bit idle_empty;
        acc = S_VALID && !m_hold_full && !m_last_seen;
        if (RESET) begin
            m_mode = 0; m_rem = 0; q_len.delete();
            m_lvl = 0; m_ur = 0; m_hold_full = 0; m_hold_last = 0;
            m_last_seen = 0; m_cur_last = 0; m_in_data = 0;
            return;
        end
        idle_empty = (m_mode == 0) && !m_hold_full;
        if (ENABLE) begin
            if (m_mode == 0) begin
                if (m_hold_full) begin
                    q_len.delete();
                    for (int i = 0; i < PC; i++) q_len.push_back(PH);
                    q_len.push_back(S1);
                    q_len.push_back(S2);
                    m_mode     = 1;
                    m_ur       = 1'b0;
                    m_cur_last = 1'b0;
                    next_segment();
                end
            end else if (m_rem > 1) begin
                m_rem--;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else begin
                next_segment();
            end
        end
        if (acc) begin
            m_hold_byte = S_DATA;
            m_hold_last = S_LAST;
            m_hold_full = 1'b1;
        end
        if (acc && S_LAST) m_last_seen = 1'b1;
        else if (idle_empty) m_last_seen = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_on) begin
                chk("level", TAPE_LEVEL, m_lvl);
                chk("busy", BUSY, m_mode != 0);
                chk("underrun", UNDERRUN, m_ur);
                chk("ready", S_READY, !m_hold_full && !m_last_seen);
                if (BUSY) busy_cnt++;
            end
        end
    end

    // Single driver for ENABLE, changed just after the falling edge.
    initial begin
        ENABLE = 1'b1;
        forever begin
            @(negedge CLK);
            #1;
            ENABLE = rand_en ? ($urandom_range(0, 7) != 0) : en_dir;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int dly);
        int t;
        repeat (dly) @(negedge CLK);
        S_VALID = 1'b1;
        S_DATA  = d;
        S_LAST  = l;
        t = 0;
        while (!S_READY && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 3000) chk("accept_timeout", 1, 0);
        @(negedge CLK);
        S_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_mode != 0 || m_hold_full || m_last_seen) && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 5000) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_model(input int what);
        int t;
        t = 0;
        while (t < 2000 && !((what == 0) ? m_ur : (m_in_data && m_hold_full))) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 2000) chk("event_timeout", 1, 0);
    endtask

    initial begin
        RESET = 1'b1; S_VALID = 1'b0; S_DATA = 8'd0; S_LAST = 1'b0;
        @(posedge CLK);
        chk_on = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_level", TAPE_LEVEL, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_underrun", UNDERRUN, 0);
        chk("rst_ready", S_READY, 1);

        // Single byte 0xA5: 12 pilot + 5 sync + 48 data + 10 pause cycles.
        busy_cnt = 0;
        send_byte(8'hA5, 1'b1, 0);
        wait_idle();
        chk("a5_busy_cycles", busy_cnt, 75);

        // Two bytes, valid held high.
        send_byte(8'hFF, 1'b0, 1);
        send_byte(8'h00, 1'b1, 0);
        wait_idle();

        // Second byte arrives 20 cycles after the boundary that missed it.
        send_byte(8'h96, 1'b0, 1);
        wait_model(0);
        chk("ur_flag", UNDERRUN, 1);
        send_byte(8'h3C, 1'b1, 20);
        wait_idle();

        // ENABLE low for 7 cycles during pilot stretches the block by 7.
        busy_cnt = 0;
        send_byte(8'hA5, 1'b1, 1);
        repeat (3) @(negedge CLK);
        en_dir = 1'b0;
        repeat (7) @(negedge CLK);
        en_dir = 1'b1;
        wait_idle();
        chk("enable_gap_busy", busy_cnt, 82);

        // Reset in DATA with a byte waiting in the hold register.
        send_byte(8'hFF, 1'b0, 1);
        send_byte(8'h3C, 1'b1, 0);
        wait_model(1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rst_data_level", TAPE_LEVEL, 0);
        chk("rst_data_busy", BUSY, 0);
        chk("rst_data_ready", S_READY, 1);
        send_byte(8'h5A, 1'b1, 2);
        wait_idle();

        // Randomised blocks with random byte delays and ENABLE dropouts.
        rand_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) begin
                send_byte(8'($urandom_range(0, 255)), (i == nb - 1),
                          int'($urandom_range(0, 30)));
            end
            wait_idle();
        end
        rand_en = 1'b0;
        repeat (4) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
